// File: rtl/qdr_multiport_arbiter.sv
// Shares one QDR controller port among N_PORTS slaves; in-order tag FIFO routes reads.
// Define QDR_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module qdr_multiport_arbiter #(
  parameter int N_PORTS        = 2,
  parameter int QDR_ADDR_WIDTH = 21,
  parameter int QDR_DATA_WIDTH = 36,
  parameter int QDR_BW_WIDTH   = 2,
  parameter int TAG_DEPTH      = 16
) (
  input  logic                                 qdr_clk,
  input  logic                                 qdr_rst,
  input  logic [32*N_PORTS-1:0]                slave_addr,
  input  logic [N_PORTS-1:0]                   slave_wr_strb,
  input  logic [2*QDR_DATA_WIDTH*N_PORTS-1:0]  slave_wr_data,
  input  logic [2*QDR_BW_WIDTH*N_PORTS-1:0]    slave_wr_be,
  input  logic [N_PORTS-1:0]                   slave_rd_strb,
  output logic [N_PORTS-1:0]                   slave_ack,
  output logic [2*QDR_DATA_WIDTH-1:0]          slave_rd_data,
  output logic [N_PORTS-1:0]                   slave_rd_dvld,
  output logic [QDR_ADDR_WIDTH-1:0]            master_addr,
  output logic                                 master_wr_strb,
  output logic [2*QDR_DATA_WIDTH-1:0]          master_wr_data,
  output logic [2*QDR_BW_WIDTH-1:0]            master_wr_be,
  output logic                                 master_rd_strb,
  input  logic [2*QDR_DATA_WIDTH-1:0]          master_rd_data,
  input  logic                                 master_rd_dvld,
  output logic                                 tag_underflow
);

  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH + 1);
  localparam int DW = 2 * QDR_DATA_WIDTH;
  localparam int BW = 2 * QDR_BW_WIDTH;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      wp_q, wp_d;
  logic [AW-1:0]      rp_q, rp_d;
  logic               unf_q, unf_d;
  logic [PW-1:0]      tag_mem [TAG_DEPTH];
  logic               full, push, pop;
  logic [N_PORTS-1:0] elig;
  logic               found;
  logic [PW-1:0]      gnt;

  assign full = (cnt_q == CW'(TAG_DEPTH));

  // Reset gating here keeps every ack and master strobe low in reset.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      elig[i] = ~qdr_rst & (slave_wr_strb[i] | slave_rd_strb[i])
              & ~(slave_rd_strb[i] & full);
    end
  end

`ifdef QDR_ARB_FIXED_PRIO_EN
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (elig[i]) begin
        found = 1'b1;
        gnt   = PW'(i);
      end
    end
  end
`else
  logic [PW-1:0] rr_q, rr_d;

  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    gnt   = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      if (!found && elig[idx]) begin
        found = 1'b1;
        gnt   = PW'(idx);
      end
    end
    rr_d = rr_q;
    if (found) rr_d = (gnt == PW'(N_PORTS - 1)) ? '0 : gnt + PW'(1);
  end

  always_ff @(posedge qdr_clk or posedge qdr_rst) begin
    if (qdr_rst) rr_q <= '0;
    else         rr_q <= rr_d;
  end
`endif

  always_comb begin
    slave_ack      = '0;
    master_addr    = '0;
    master_wr_strb = 1'b0;
    master_wr_data = '0;
    master_wr_be   = '0;
    master_rd_strb = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (found && gnt == PW'(i)) begin
        slave_ack[i]   = 1'b1;
        master_addr    = slave_addr[32*i +: QDR_ADDR_WIDTH];
        master_wr_strb = slave_wr_strb[i];
        master_wr_data = slave_wr_data[DW*i +: DW];
        master_wr_be   = slave_wr_be[BW*i +: BW];
        master_rd_strb = slave_rd_strb[i];
      end
    end
  end

  assign push          = master_rd_strb;
  assign pop           = master_rd_dvld & (cnt_q != '0) & ~qdr_rst;
  assign slave_rd_data = master_rd_data;
  assign slave_rd_dvld = pop ? (N_PORTS'(1) << tag_mem[rp_q]) : '0;
  assign tag_underflow = unf_q;

  always_comb begin
    wp_d  = push ? wp_q + AW'(1) : wp_q;
    rp_d  = pop ? rp_q + AW'(1) : rp_q;
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + CW'(1);
    if (pop && !push) cnt_d = cnt_q - CW'(1);
    unf_d = unf_q | (master_rd_dvld & (cnt_q == '0));
  end

  always_ff @(posedge qdr_clk or posedge qdr_rst) begin
    if (qdr_rst) begin
      cnt_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge qdr_clk) begin
    if (push) tag_mem[wp_q] <= gnt;
  end

endmodule
